leg_solver: RTL and testbench

- Inverse companion of the vector-magnitude block: given hypotenuse r and one leg x, computes the other leg y = floor(sqrt(r^2 - x^2)).
- Multi-cycle, iterative datapath with no multipliers: shift-add squaring followed by bit-serial restoring square root.
- Start/busy/done handshake.
- Sits beside the magnitude unit so the design can both measure and decompose vectors.

---
 rtl/leg_solver_if.sv | 15 +
 rtl/leg_solver.sv | 126 ++++++++++++
 tb/tb_leg_solver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/leg_solver_if.sv
// leg_solver_if: request/operand and result bus for the leg solver.
interface leg_solver_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] r_in;
  logic [W-1:0] x_in;
  logic [W-1:0] y_out;
  logic         busy;
  logic         done;
  logic         err;

  modport master (output start, r_in, x_in, input y_out, busy, done, err);
  modport slave  (input start, r_in, x_in, output y_out, busy, done, err);
endinterface

// File: rtl/leg_solver.sv
// leg_solver: y = floor(sqrt(r^2 - x^2)) using shift-add squaring followed by
// a bit-serial restoring square root; start/busy/done handshake.
module leg_solver #(
  parameter int unsigned W = 8
) (
  input  logic        clk,
  input  logic        rst,
  leg_solver_if.slave bus
);
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RW = W + 2;  // remainder never exceeds 2*root
  localparam int unsigned TW = W + 4;  // trial operands: remainder plus two new bits

  typedef enum logic [2:0] {IDLE, SQUARE, SUB, ROOT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] step;
  logic [W2-1:0] r_mc, x_mc;   // shifting multiplicands
  logic [W-1:0]  r_mp, x_mp;   // shifting multipliers
  logic [W2-1:0] rsq, xsq;
  logic [W2-1:0] diff;
  logic [W-1:0]  root;
  logic [RW-1:0] rem;
  logic          neg;

  // Restoring-root trial for the next two diff bits
  logic [TW-1:0] trial_a;
  logic [TW-1:0] trial_b;
  logic          trial_ok;
  logic [W-1:0]  root_nxt;

  assign trial_a  = {rem, diff[W2-1 -: 2]};
  assign trial_b  = {2'b00, root, 2'b01};
  assign trial_ok = (trial_a >= trial_b);
  assign root_nxt = {root[W-2:0], trial_ok};

  // Control FSM and iterative datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      r_mc      <= '0;
      x_mc      <= '0;
      r_mp      <= '0;
      x_mp      <= '0;
      rsq       <= '0;
      xsq       <= '0;
      diff      <= '0;
      root      <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      bus.y_out <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= SQUARE;
            step     <= '0;
            bus.busy <= 1'b1;
            r_mc     <= W2'(bus.r_in);
            x_mc     <= W2'(bus.x_in);
            r_mp     <= bus.r_in;
            x_mp     <= bus.x_in;
            rsq      <= '0;
            xsq      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SQUARE: begin
          if (r_mp[0]) rsq <= rsq + r_mc;
          if (x_mp[0]) xsq <= xsq + x_mc;
          r_mc <= r_mc << 1;
          x_mc <= x_mc << 1;
          r_mp <= r_mp >> 1;
          x_mp <= x_mp >> 1;
          if (step == CW'(W - 1)) begin
            state <= SUB;
            step  <= '0;
          end else begin
            step <= step + CW'(1);
          end
        end
        SUB: begin
          if (rsq < xsq) begin
            neg  <= 1'b1;
            diff <= '0;
          end else begin
            neg  <= 1'b0;
            diff <= rsq - xsq;
          end
          rem   <= '0;
          root  <= '0;
          step  <= '0;
          state <= ROOT;
        end
        ROOT: begin
          if (trial_ok) rem <= RW'(trial_a - trial_b);
          else          rem <= RW'(trial_a);
          root <= root_nxt;
          diff <= diff << 2;
          if (step == CW'(W - 1)) begin
            state     <= DONE;
            step      <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.y_out <= root_nxt;
            bus.err   <= neg;
          end else begin
            step <= step + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          step     <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_leg_solver.sv
// tb_leg_solver: directed and random checks of leg_solver with an
// expected-result queue filled at launch and drained at each done pulse.
module tb_leg_solver;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 18;

  typedef struct packed {
    logic [W-1:0] y;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  leg_solver_if #(.W(W)) bus ();

  leg_solver #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: floor(sqrt(max(r^2 - x^2, 0))), err when x > r
  function automatic exp_t model(input logic [W-1:0] r, input logic [W-1:0] x);
    exp_t e;
    int   d;
    int   y;
    if (x > r) begin
      e.y   = '0;
      e.err = 1'b1;
      return e;
    end
    d = int'(r) * int'(r) - int'(x) * int'(x);
    y = 0;
    while ((y + 1) * (y + 1) <= d) y++;
    e.y   = W'(y);
    e.err = 1'b0;
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] r, input logic [W-1:0] x);
    bus.r_in  = r;
    bus.x_in  = x;
    bus.start = 1'b1;
    exp_q.push_back(model(r, x));
  endtask

  // Follow one run from launch to its done cycle; optionally disturb inputs while busy
  task automatic track(input bit full, input bit disturb, input string tag);
    exp_t e;
    for (int n = 1; n <= int'(LAT); n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.start = 1'b0;
      if (disturb && n >= 2 && n <= int'(LAT) - 2) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.r_in  = W'($urandom);
        bus.x_in  = W'($urandom);
      end
      if (disturb && n == int'(LAT) - 1) bus.start = 1'b0;
      if (full && n < int'(LAT)) begin
        chk({tag, "_busy"},   16'(bus.busy), 16'd1);
        chk({tag, "_nodone"}, 16'(bus.done), 16'd0);
      end
    end
    chk({tag, "_done"},     16'(bus.done), 16'd1);
    chk({tag, "_busy_lo"},  16'(bus.busy), 16'd0);
    e = exp_q.pop_front();
    chk({tag, "_y"},   16'(bus.y_out), 16'(e.y));
    chk({tag, "_err"}, 16'(bus.err),   16'(e.err));
  endtask

  task automatic run_op(input logic [W-1:0] r, input logic [W-1:0] x,
                        input bit full, input string tag);
    @(posedge clk); #1;
    launch(r, x);
    track(full, 1'b0, tag);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.r_in  = '0;
    bus.x_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_y",    16'(bus.y_out), 16'd0);
    chk("rst_busy", 16'(bus.busy),  16'd0);
    chk("rst_done", 16'(bus.done),  16'd0);
    chk("rst_err",  16'(bus.err),   16'd0);

    run_op(8'd5, 8'd3, 1'b1, "r5x3");

    // Result held and done deasserted after the pulse
    repeat (3) @(posedge clk);
    #1;
    chk("hold_y",    16'(bus.y_out), 16'd4);
    chk("hold_done", 16'(bus.done),  16'd0);
    chk("hold_busy", 16'(bus.busy),  16'd0);

    run_op(8'd255, 8'd0,   1'b1, "r255x0");
    run_op(8'd10,  8'd10,  1'b1, "r10x10");
    run_op(8'd255, 8'd254, 1'b1, "r255x254");
    run_op(8'd13,  8'd7,   1'b1, "r13x7");
    run_op(8'd3,   8'd5,   1'b1, "r3x5");
    run_op(8'd5,   8'd4,   1'b1, "r5x4");

    // Operand changes and start pulses while busy are ignored
    @(posedge clk); #1;
    launch(8'd13, 8'd7);
    track(1'b1, 1'b1, "disturb");

    // start held in the DONE cycle launches a back-to-back run
    launch(8'd255, 8'd254);
    track(1'b1, 1'b0, "b2b");

    // Reset in cycle 10 of a run aborts it without a done pulse
    @(posedge clk); #1;
    launch(8'd200, 8'd100);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 16'(bus.busy),  16'd0);
    chk("abort_done", 16'(bus.done),  16'd0);
    chk("abort_y",    16'(bus.y_out), 16'd0);
    chk("abort_err",  16'(bus.err),   16'd0);
    void'(exp_q.pop_back());
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("abort_no_done", 16'(seen), 16'd0);

    run_op(8'd5, 8'd3, 1'b1, "post_rst");

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, "rand");
    end

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
